serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial addition sequencer that time-shares one external single-bit full-adder cell (inputs e1, e2, cin; outputs sum, cout) to add two WIDTH-bit operands, LSB first.
- Captures operands on a start pulse and presents one bit pair plus the registered carry to the cell each cycle.
- Collects the sum bits and the final carry, then pulses done.
- Sits between a requesting FSM or bus register and the shared adder cell. It is the cell's only driver.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 32).
- CW, 6, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request pulse; sampled only in IDLE or DONE.
- a, input, WIDTH, operand A; captured on accepted start.
- b, input, WIDTH, operand B; captured on accepted start.
- cin, input, 1, carry-in; captured on accepted start.
- busy, output, 1, high while state is RUN.
- done, output, 1, one-cycle pulse when result becomes valid.
- sum, output, WIDTH, result; held stable from done until the next accepted start.
- cout, output, 1, final carry-out; same validity as sum.
- fa_e1, output, 1, to adder cell e1.
- fa_e2, output, 1, to adder cell e2.
- fa_cin, output, 1, to adder cell cin.
- fa_sum, input, 1, from adder cell sum (combinational from fa_e1, fa_e2, fa_cin).
- fa_cout, input, 1, from adder cell cout (combinational).

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - fa_e1, fa_e2, fa_cin = 0; internal shift registers, carry and counter = 0.
  - Any in-flight operation is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - fa_e1=a_sh[0], fa_e2=b_sh[0], fa_cin=carry (combinational from registers).
  - At each edge: sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with zero fill; carry<=fa_cout; cnt<=cnt+1.
  - The edge where cnt==WIDTH-1 is the last bit: go to DONE; sum<=final sum_sh value including this bit; cout<=fa_cout.
  - RUN lasts exactly WIDTH cycles. start is ignored in RUN; no queuing and no restart.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 at this edge: accepted exactly as from IDLE (back-to-back operation, no idle bubble); done still pulses this cycle.
  - Otherwise go to IDLE.
- fa_e1, fa_e2, fa_cin = 0 in IDLE and DONE.
- busy=1 only in RUN.
- sum and cout change only at the RUN→DONE edge or on reset.
- Latency: start accepted at edge 0 → done high during the cycle after edge WIDTH; result visible from that same cycle.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts a single cycle; the counter compare must still hold.
- Operand inputs may change freely after the accepting edge without affecting the result.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, start one cycle → busy high 8 cycles; done pulses in the cycle after edge 8; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1. a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0.
- Start a=8'h12, b=8'h34 → pulse start again with a=8'hFF, b=8'hFF at RUN cycle 3 → result sum=8'h46, cout=0; exactly one done pulse; second request ignored.
- Hold start high continuously with a=8'h01, b=8'h01 → done every 9 cycles, sum=8'h02 each time; busy low only during the DONE cycles.
- Assert rst asynchronously during RUN cycle 5 → all outputs and fa_* go 0 immediately with no clock; no done pulse; a fresh start afterwards computes correctly.
- Sweep all 512 a/b/cin combinations at WIDTH=4 and 1,000 random vectors at WIDTH=8 against a behavioural model, with a reference full-adder cell connected → every {cout,sum} matches; fa_* are 0 whenever busy=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition sequencer: time-shares one external full-adder cell,
// feeding it one operand bit pair per cycle LSB first and collecting the sum.
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_e1,
    output logic             fa_e2,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             load_s;
    logic             shift_s;
    logic             last_s;
    logic [WIDTH:0]   sum_cat_s;
    logic [WIDTH-1:0] sum_sh_nxt_s;

    // New sum bit enters at the MSB; built via concatenation so WIDTH=1 works.
    assign sum_cat_s    = {fa_sum, sum_sh_r};
    assign sum_sh_nxt_s = sum_cat_s[WIDTH:1];
    assign last_s       = (cnt_r == LAST_CNT);

    assign busy   = busy_r;
    assign done   = done_r;
    assign sum    = sum_r;
    assign cout   = cout_r;
    assign fa_e1  = busy_r & a_sh_r[0];
    assign fa_e2  = busy_r & b_sh_r[0];
    assign fa_cin = busy_r & carry_r;

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                shift_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand shifters, carry, bit counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else if (load_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= cin;
            cnt_r    <= {CW{1'b0}};
        end else if (shift_s) begin
            a_sh_r   <= a_sh_r >> 1'b1;
            b_sh_r   <= b_sh_r >> 1'b1;
            sum_sh_r <= sum_sh_nxt_s;
            carry_r  <= fa_cout;
            cnt_r    <= cnt_r + CW'(1);
            if (last_s) begin
                sum_r  <= sum_sh_nxt_s;
                cout_r <= fa_cout;
            end
        end
    end

endmodule
